// File: rtl/sequencer_fetch.sv
// Instruction fetch/execute sequencer: fetches 16-bit words, strobes the ALU, tracks CARRY/SKIP flags.
// Optional HALT state is enabled by defining the macro SEQ_HALT_EN.
module sequencer_fetch (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic [15:0] ir,
    output logic        exec1,
    input  logic        carryout,
    input  logic        carryen,
    input  logic        skipout,
    input  logic        skipen,
    output logic        carrystatus,
    output logic        skipstatus,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_HLT = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;

    state_t      r_state;
    state_t      w_stateNext;
    logic [7:0]  r_pc;
    logic [7:0]  w_pcNext;
    logic [15:0] r_ir;
    logic [15:0] w_irNext;
    logic        r_carry;
    logic        w_carryNext;
    logic        r_skip;
    logic        w_skipNext;
    logic [1:0]  w_opcode;

    assign w_opcode = r_ir[15:14];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= 8'h00;
            r_ir    <= 16'h0000;
            r_carry <= 1'b0;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            r_ir    <= w_irNext;
            r_carry <= w_carryNext;
            r_skip  <= w_skipNext;
        end
    end

    // A pending skip consumes the fetched word in place of loading it into IR.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_irNext    = r_ir;
        w_carryNext = r_carry;
        w_skipNext  = r_skip;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_pcNext = r_pc + 8'd1;
                    if (r_skip) begin
                        w_skipNext = 1'b0;
                    end else begin
                        w_irNext    = mem_data;
                        w_stateNext = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (carryen) begin
                    w_carryNext = carryout;
                end
                if (skipen) begin
                    w_skipNext = skipout;
                end
                w_stateNext = ST_FETCH;
                if (w_opcode == OP_JMP) begin
                    w_pcNext = r_ir[7:0];
                end
`ifdef SEQ_HALT_EN
                if (w_opcode == OP_HLT) begin
                    w_stateNext = ST_HALT;
                end
`endif
            end
`ifdef SEQ_HALT_EN
            ST_HALT: begin
                w_stateNext = ST_HALT;
            end
`endif
            default: begin
                w_stateNext = ST_FETCH;
            end
        endcase
    end

    assign mem_addr    = r_pc;
    assign mem_rd      = (r_state == ST_FETCH);
    assign exec1       = (r_state == ST_EXEC);
    assign ir          = r_ir;
    assign carrystatus = r_carry;
    assign skipstatus  = r_skip;

`ifdef SEQ_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
    logic w_unusedOpcode;
    assign w_unusedOpcode = (OP_HLT == OP_NOP);
`endif

endmodule

// File: tb/tb_sequencer_fetch.sv
// Directed, table-driven testbench for sequencer_fetch; honours SEQ_HALT_EN if defined.
module tb_sequencer_fetch;

    logic        clk;
    logic        reset;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [15:0] ir;
    logic        exec1;
    logic        carryout;
    logic        carryen;
    logic        skipout;
    logic        skipen;
    logic        carrystatus;
    logic        skipstatus;
    logic        halted;

    int testsRun    = 0;
    int testsFailed = 0;

`ifdef SEQ_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        rst;
        logic        rdy;
        logic [15:0] data;
        logic        cOut;
        logic        cEn;
        logic        sOut;
        logic        sEn;
        logic [7:0]  eAddr;
        logic        eRd;
        logic [15:0] eIr;
        logic        eExec;
        logic        eCarry;
        logic        eSkip;
        logic        eHalt;
    } vec_t;

    vec_t vecs[$];

    sequencer_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .ir          (ir),
        .exec1       (exec1),
        .carryout    (carryout),
        .carryen     (carryen),
        .skipout     (skipout),
        .skipen      (skipen),
        .carrystatus (carrystatus),
        .skipstatus  (skipstatus),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic rst, input logic rdy, input logic [15:0] data,
                          input logic cOut, input logic cEn, input logic sOut, input logic sEn,
                          input logic [7:0] eAddr, input logic eRd, input logic [15:0] eIr,
                          input logic eExec, input logic eCarry, input logic eSkip, input logic eHalt);
        vec_t v;
        v.name = name; v.rst = rst; v.rdy = rdy; v.data = data;
        v.cOut = cOut; v.cEn = cEn; v.sOut = sOut; v.sEn = sEn;
        v.eAddr = eAddr; v.eRd = eRd; v.eIr = eIr; v.eExec = eExec;
        v.eCarry = eCarry; v.eSkip = eSkip; v.eHalt = eHalt;
        vecs.push_back(v);
    endtask

    // Drive inputs for one clock edge, then let outputs settle just after it.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic [15:0] data,
                                 input logic cOut, input logic cEn, input logic sOut, input logic sEn);
        reset     = rst;
        mem_ready = rdy;
        mem_data  = data;
        carryout  = cOut;
        carryen   = cEn;
        skipout   = sOut;
        skipen    = sEn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eAddr, input logic eRd,
                               input logic [15:0] eIr, input logic eExec, input logic eCarry,
                               input logic eSkip, input logic eHalt);
        logic [28:0] got;
        logic [28:0] exp;
        got = {mem_addr, mem_rd, ir, exec1, carrystatus, skipstatus, halted};
        exp = {eAddr, eRd, eIr, eExec, eCarry, eSkip, eHalt};
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got addr=%02h rd=%b ir=%04h exec1=%b c=%b s=%b halt=%b, expected addr=%02h rd=%b ir=%04h exec1=%b c=%b s=%b halt=%b",
                     name, mem_addr, mem_rd, ir, exec1, carrystatus, skipstatus, halted,
                     eAddr, eRd, eIr, eExec, eCarry, eSkip, eHalt);
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; mem_data = 16'h0000;
        carryout = 1'b0; carryen = 1'b0; skipout = 1'b0; skipen = 1'b0;

        //      name            rst rdy data     cO cE sO sE  addr  rd ir       ex c  s  h
        addVec("reset",          1, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 16'h0000, 0, 0, 0, 0);
        addVec("fetchC000",      0, 1, 16'hC000, 0, 0, 0, 0, 8'h01, 0, 16'hC000, 1, 0, 0, 0);
        addVec("execAlu",        0, 1, 16'hC000, 0, 0, 0, 0, 8'h01, 1, 16'hC000, 0, 0, 0, 0);
        addVec("stall1",         0, 0, 16'h1234, 0, 0, 0, 0, 8'h01, 1, 16'hC000, 0, 0, 0, 0);
        addVec("stall2",         0, 0, 16'h1234, 0, 0, 0, 0, 8'h01, 1, 16'hC000, 0, 0, 0, 0);
        addVec("stall3",         0, 0, 16'h1234, 0, 0, 0, 0, 8'h01, 1, 16'hC000, 0, 0, 0, 0);
        addVec("fetchAfterStall",0, 1, 16'h3000, 0, 0, 0, 0, 8'h02, 0, 16'h3000, 1, 0, 0, 0);
        addVec("execSetFlags",   0, 1, 16'h3000, 1, 1, 1, 1, 8'h02, 1, 16'h3000, 0, 1, 1, 0);
        addVec("skipDiscard",    0, 1, 16'hC555, 0, 0, 0, 0, 8'h03, 1, 16'h3000, 0, 1, 0, 0);
        addVec("fetchJmp10",     0, 1, 16'h8010, 0, 0, 0, 0, 8'h04, 0, 16'h8010, 1, 1, 0, 0);
        addVec("execJmp10",      0, 1, 16'h8010, 0, 1, 0, 0, 8'h10, 1, 16'h8010, 0, 0, 0, 0);
        addVec("fetchJmp42",     0, 1, 16'h8042, 0, 0, 0, 0, 8'h11, 0, 16'h8042, 1, 0, 0, 0);
        addVec("execJmp42",      0, 1, 16'h8042, 0, 0, 0, 0, 8'h42, 1, 16'h8042, 0, 0, 0, 0);
        addVec("fetchJmpFF",     0, 1, 16'h80FF, 0, 0, 0, 0, 8'h43, 0, 16'h80FF, 1, 0, 0, 0);
        addVec("execJmpSkip",    0, 1, 16'h80FF, 0, 0, 1, 1, 8'hFF, 1, 16'h80FF, 0, 0, 1, 0);
        addVec("discardWrap",    0, 1, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 16'h80FF, 0, 0, 0, 0);
        addVec("fetchJmpFE",     0, 1, 16'h80FE, 0, 0, 0, 0, 8'h01, 0, 16'h80FE, 1, 0, 0, 0);
        addVec("execJmpFE",      0, 1, 16'h80FE, 0, 0, 0, 0, 8'hFE, 1, 16'h80FE, 0, 0, 0, 0);
        addVec("fetchAtFE",      0, 1, 16'hC000, 0, 0, 0, 0, 8'hFF, 0, 16'hC000, 1, 0, 0, 0);
        addVec("execAtFE",       0, 1, 16'hC000, 0, 0, 0, 0, 8'hFF, 1, 16'hC000, 0, 0, 0, 0);
        addVec("fetchWrap",      0, 1, 16'h0001, 0, 0, 0, 0, 8'h00, 0, 16'h0001, 1, 0, 0, 0);
        addVec("execNoEnable",   0, 1, 16'h0001, 1, 0, 1, 0, 8'h00, 1, 16'h0001, 0, 0, 0, 0);
        addVec("noFlagInFetch",  0, 0, 16'h0001, 1, 1, 1, 1, 8'h00, 1, 16'h0001, 0, 0, 0, 0);
        addVec("fetch4000",      0, 1, 16'h4000, 0, 0, 0, 0, 8'h01, 0, 16'h4000, 1, 0, 0, 0);
        addVec("exec4000",       0, 1, 16'hC000, 0, 0, 0, 0, 8'h01, !HALT_EN, 16'h4000, 0, 0, 0, HALT_EN);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].data, vecs[i].cOut, vecs[i].cEn,
                          vecs[i].sOut, vecs[i].sEn);
            checkOutput(vecs[i].name, vecs[i].eAddr, vecs[i].eRd, vecs[i].eIr, vecs[i].eExec,
                        vecs[i].eCarry, vecs[i].eSkip, vecs[i].eHalt);
        end

`ifdef SEQ_HALT_EN
        // HALT ignores memory and ALU flag inputs until reset.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 16'hC000, 1'b1, 1'b1, 1'b1, 1'b1);
            checkOutput("haltPersist", 8'h01, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
        end
`else
        applyStimulus(1'b0, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("nopContinues", 8'h02, 1'b0, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("nopContExec", 8'h02, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("resetAgain", 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while a fetch is stalled, with both flags set beforehand.
        applyStimulus(1'b0, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rsStallFetch", 8'h01, 1'b0, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hC000, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rsStallExec", 8'h01, 1'b1, 16'hC000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rsStalled", 8'h01, 1'b1, 16'hC000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("resetInStall", 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during EXEC of a JMP must beat both the jump and the flag writes.
        applyStimulus(1'b0, 1'b1, 16'h8020, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reFetchJmp", 8'h01, 1'b0, 16'h8020, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h8020, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("resetInExec", 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hC001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("postResetFetch", 8'h01, 1'b0, 16'hC001, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
